sensor_conditioner: RTL

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

---
 rtl/sensor_pkg.sv | 16 +
 rtl/sensor_conditioner_if.sv | 27 ++
 rtl/deb_channel.sv | 57 +++++
 rtl/sensor_conditioner.sv | 97 +++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared constants and types for the sensor conditioner: channel count,
// channel indices and default prescaler/debounce settings.
package sensor_pkg;

  localparam int NUM_CH    = 4;
  localparam int CH_US     = 0;
  localparam int CH_BS     = 1;
  localparam int CH_VS     = 2;
  localparam int CH_ADUB   = 3;

  localparam int DIV_N_DEF = 50000;
  localparam int DEB_N_DEF = 8;

  typedef logic [NUM_CH-1:0] ch_vec_t;

endpackage

// File: rtl/sensor_conditioner_if.sv
// Sensor bundle between the switch panel and the irrigation controller:
// raw switch levels in one direction, conditioned levels, change pulses and conflict flag back.
interface sensor_conditioner_if;
  import sensor_pkg::*;

  logic    us_raw;
  logic    bs_raw;
  logic    vs_raw;
  logic    adub_raw;
  logic    us;
  logic    bs;
  logic    vs;
  logic    adub;
  ch_vec_t chg;
  logic    sel_err;

  modport master (
    output us_raw, bs_raw, vs_raw, adub_raw,
    input  us, bs, vs, adub, chg, sel_err
  );

  modport slave (
    input  us_raw, bs_raw, vs_raw, adub_raw,
    output us, bs, vs, adub, chg, sel_err
  );

endinterface

// File: rtl/deb_channel.sv
// One switch channel: 2-flop synchronizer, tick-gated agreement counter, debounced state, change pulse.
// state/chg update on the clock edge that ends the DEB_N-th consecutive disagreeing tick.
module deb_channel
  import sensor_pkg::*;
#(
  parameter int DEB_N = DEB_N_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic tick,
  output logic state,
  output logic state_nxt,
  output logic chg
);

  logic       sync_meta;
  logic       sync_q;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       chg_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      state     <= 1'b0;
      cnt       <= 4'd0;
      chg       <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      chg       <= chg_nxt;
    end
  end

  // Counter tops out at DEB_N-1 and is cleared on acceptance, so it never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    chg_nxt   = 1'b0;
    if (tick) begin
      if (sync_q == state) begin
        cnt_nxt = 4'd0;
      end else if (cnt == 4'(DEB_N - 1)) begin
        state_nxt = ~state;
        cnt_nxt   = 4'd0;
        chg_nxt   = 1'b1;
      end else begin
        cnt_nxt = cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/sensor_conditioner.sv
// Debounces four irrigation switches on a shared prescaler tick and flags drip/sprinkler conflicts.
// Build with SENSOR_ERR_LATCH_EN to make the conflict flag sticky until reset.
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int DIV_N = DIV_N_DEF,
  parameter int DEB_N = DEB_N_DEF
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Us_raw,
  input  logic       Bs_raw,
  input  logic       Vs_raw,
  input  logic       Adub_raw,
  output logic       Us,
  output logic       Bs,
  output logic       Vs,
  output logic       Adub,
  output logic [3:0] Chg,
  output logic       Sel_err
);

  localparam int PW = $clog2(DIV_N);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV_N - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;
  ch_vec_t       raw_vec;
  ch_vec_t       st;
  ch_vec_t       st_nxt;
  ch_vec_t       chg_vec;
  logic          conflict_nxt;
  logic          err_nxt;
  logic          sel_err_q;
  logic          bs_q;
  logic          vs_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  assign tick = (pre_cnt == PRE_LAST);

  assign raw_vec[CH_US]   = Us_raw;
  assign raw_vec[CH_BS]   = Bs_raw;
  assign raw_vec[CH_VS]   = Vs_raw;
  assign raw_vec[CH_ADUB] = Adub_raw;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    deb_channel #(
      .DEB_N (DEB_N)
    ) u_deb (
      .clk       (Clk),
      .rst_n     (Rst),
      .raw       (raw_vec[i]),
      .tick      (tick),
      .state     (st[i]),
      .state_nxt (st_nxt[i]),
      .chg       (chg_vec[i])
    );
  end

  // Conflict is judged on next-state values so the masked outputs line up with Us/Adub and Chg.
  assign conflict_nxt = st_nxt[CH_BS] & st_nxt[CH_VS];

`ifdef SENSOR_ERR_LATCH_EN
  assign err_nxt = sel_err_q | conflict_nxt;
`else
  assign err_nxt = conflict_nxt;
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sel_err_q <= 1'b0;
      bs_q      <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      sel_err_q <= err_nxt;
      bs_q      <= st_nxt[CH_BS] & ~err_nxt;
      vs_q      <= st_nxt[CH_VS] & ~err_nxt;
    end
  end

  assign Us      = st[CH_US];
  assign Adub    = st[CH_ADUB];
  assign Bs      = bs_q;
  assign Vs      = vs_q;
  assign Chg     = chg_vec;
  assign Sel_err = sel_err_q;

endmodule
